// File: rtl/cpu_boot_sequencer.sv
// Host-side boot sequencer: loads the core's instruction and data memories,
// runs the core for a fixed number of cycles, then streams a data region back.
module cpu_boot_sequencer #(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   start,
    input  logic [IMEM_ADDR_W:0]   imem_words,
    input  logic [DMEM_ADDR_W:0]   dmem_words,
    input  logic [CNT_W-1:0]       run_cycles,
    input  logic [DMEM_ADDR_W:0]   dump_words,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic                   cpu_enable,
    output logic [63:0]            addr_ext,
    output logic                   wen_ext,
    output logic                   ren_ext,
    output logic [31:0]            wdata_ext,
    output logic [63:0]            addr_ext_2,
    output logic                   wen_ext_2,
    output logic                   ren_ext_2,
    output logic [63:0]            wdata_ext_2,
    input  logic [63:0]            rdata_ext_2,
    output logic                   busy,
    output logic                   done
);

    // One word counter serves both memories, so it is sized for the wider one.
    localparam int CW = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_I     = 3'd1;
    localparam logic [2:0] LD_D     = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] DUMP_RD  = 3'd4;
    localparam logic [2:0] DUMP_WT  = 3'd5;
    localparam logic [2:0] DUMP_OUT = 3'd6;

    logic [2:0]       state, state_d;
    logic [CW-1:0]    count, count_d;
    logic [CW-1:0]    imem_lim, dmem_lim, dump_lim;
    logic [CNT_W-1:0] run_lim;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_d;

    // NOTE: state updates use non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            count    <= '0;
            cyc_cnt  <= '0;
            imem_lim <= '0;
            dmem_lim <= '0;
            dump_lim <= '0;
            run_lim  <= '0;
            out_data <= '0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            cyc_cnt <= cyc_cnt_d;
            if (state == IDLE && start) begin
                imem_lim <= CW'(imem_words);
                dmem_lim <= CW'(dmem_words);
                dump_lim <= CW'(dump_words);
                run_lim  <= run_cycles;
            end
            if (state == DUMP_WT) begin
                out_data <= rdata_ext_2;
            end
        end
    end

    // All strobes are decoded from the registered state, so an asynchronous
    // reset drops every one of them in the same cycle it is asserted.
    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d     = state;
        count_d     = count;
        cyc_cnt_d   = cyc_cnt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        cpu_enable  = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    state_d = LD_I;
                end
            end

            LD_I: begin
                if (count < imem_lim) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        wen_ext   = 1'b1;
                        addr_ext  = 64'({count, 2'b00});
                        wdata_ext = in_data[31:0];
                        count_d   = count + CW'(1);
                    end
                end else begin
                    count_d = '0;
                    state_d = LD_D;
                end
            end

            LD_D: begin
                if (count < dmem_lim) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        wen_ext_2   = 1'b1;
                        addr_ext_2  = 64'({count, 3'b000});
                        wdata_ext_2 = in_data;
                        count_d     = count + CW'(1);
                    end
                end else begin
                    count_d   = '0;
                    cyc_cnt_d = run_lim;
                    state_d   = RUN;
                end
            end

            // The extra cycle with the counter at zero keeps the enable
            // pulse exactly run_cycles long, including the zero case.
            RUN: begin
                if (cyc_cnt != '0) begin
                    cpu_enable = 1'b1;
                    cyc_cnt_d  = cyc_cnt - CNT_W'(1);
                end else begin
                    state_d = DUMP_RD;
                end
            end

            DUMP_RD: begin
                if (count < dump_lim) begin
                    ren_ext_2  = 1'b1;
                    addr_ext_2 = 64'({count, 3'b000});
                    state_d    = DUMP_WT;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end

            DUMP_WT: begin
                state_d = DUMP_OUT;
            end

            DUMP_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    count_d = count + CW'(1);
                    state_d = DUMP_RD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ren_ext = 1'b0;
    assign busy    = (state != IDLE);

endmodule

// File: doc/cpu_boot_sequencer.md
Name: cpu_boot_sequencer

Overview:
- Host-side controller that sequences one complete program run of the pipelined RISC-V core.
- Per run it:
  - streams a program image into instruction memory through the core's external port;
  - streams initial data into data memory through the core's external port;
  - raises the core enable for a programmed number of cycles;
  - streams a data-memory region back to the host.
- Sits between a testbench/host stream interface and the core's addr_ext*/wen_ext*/ren_ext*/enable pins. It is the sole driver of those pins.

Parameters:
- IMEM_ADDR_W, 9, word-address width of instruction memory; max image = 2^IMEM_ADDR_W words.
- DMEM_ADDR_W, 10, word-address width of data memory; max data/dump = 2^DMEM_ADDR_W words.
- CNT_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a sequence when idle
- imem_words  in  IMEM_ADDR_W+1  number of 32-bit instruction words to load
- dmem_words  in  DMEM_ADDR_W+1  number of 64-bit data words to load
- run_cycles  in  CNT_W  number of cycles cpu_enable is held high
- dump_words  in  DMEM_ADDR_W+1  number of 64-bit data words to read back
- in_valid  in  1  host load-stream valid
- in_ready  out  1  host load-stream ready
- in_data  in  64  load word; bits [31:0] only during instruction load
- out_valid  out  1  dump-stream valid
- out_ready  in  1  dump-stream ready
- out_data  out  64  dump word
- cpu_enable  out  1  core enable
- addr_ext  out  64  instruction-memory external byte address
- wen_ext  out  1  instruction-memory external write enable
- ren_ext  out  1  instruction-memory external read enable; tied 0
- wdata_ext  out  32  instruction-memory external write data
- addr_ext_2  out  64  data-memory external byte address
- wen_ext_2  out  1  data-memory external write enable
- ren_ext_2  out  1  data-memory external read enable
- wdata_ext_2  out  64  data-memory external write data
- rdata_ext_2  in  64  data-memory external read data; valid the cycle after ren_ext_2
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the DUMP→IDLE transition

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0: in_ready, out_valid, out_data, cpu_enable, all addr/wen/ren/wdata outputs, busy, done.
  - Word and cycle counters are 0.
  - Reset asserted mid-sequence aborts immediately. No partial write completes after arst_n falls.
- State machine: IDLE → LD_I → LD_D → RUN → DUMP_RD → DUMP_WT → DUMP_OUT → IDLE.
- IDLE:
  - start=1 latches imem_words, dmem_words, run_cycles and dump_words, and clears the word counter.
  - Next state is LD_I.
  - start outside IDLE is ignored.
- LD_I:
  - in_ready=1 while count < imem_words. Each cycle with in_valid&in_ready produces, combinationally in that cycle:
    - wen_ext=1;
    - addr_ext = count*4 (zero-extended);
    - wdata_ext = in_data[31:0];
    - count increments.
  - When count == imem_words: in_ready=0, count clears, next state is LD_D. This applies immediately when imem_words=0, so the state takes 1 cycle.
- LD_D:
  - Same as LD_I, but drives wen_ext_2, addr_ext_2 = count*8 and wdata_ext_2 = in_data, with limit dmem_words.
  - Exit to RUN loads the cycle counter with run_cycles.
- RUN:
  - cpu_enable=1 while the cycle counter is nonzero; the counter decrements each cycle.
  - When the counter is 0, cpu_enable=0 and next state is DUMP_RD.
  - Result: cpu_enable is high for exactly run_cycles consecutive cycles. run_cycles=0 gives no enable pulse.
  - All ext write/read enables are 0 in RUN.
- DUMP_RD:
  - If count < dump_words: ren_ext_2=1, addr_ext_2 = count*8, next state DUMP_WT.
  - Otherwise: done=1, next state IDLE.
- DUMP_WT: capture rdata_ext_2 into the out_data register, then go to DUMP_OUT.
- DUMP_OUT:
  - out_valid=1 and out_data stays stable until out_ready.
  - On out_valid&out_ready: count increments, next state DUMP_RD.
  - Throughput is 1 word per 3 cycles minimum.
- Address/width rules:
  - The word counter wraps at 2^(ADDR_W+1). Counts never exceed the parameter maximum, so wrap is not reachable for legal inputs.
  - Byte addresses use the full 64 bits, upper bits 0.
- Exclusivity: at most one of wen_ext, wen_ext_2, ren_ext_2, cpu_enable is high in any cycle.
- Backpressure: in_valid low stalls a load state indefinitely with no write issued. out_ready low holds DUMP_OUT.

Test Plan:
- Reset during LD_D after 3 of 5 words → all outputs 0 the same cycle; busy=0; next start restarts at imem address 0.
- start with imem_words=4, in_data=0x…00000013,0x…00100093,0x…00200113,0x…00308193 streamed back-to-back → wen_ext high 4 cycles, addr_ext 0,4,8,12, wdata_ext equals the low words; readback via the core's ren_ext matches.
- dmem_words=2 with in_valid toggling 1,0,1 → exactly 2 wen_ext_2 pulses at addresses 0 and 8; no write on the idle cycle.
- run_cycles=7 → cpu_enable high exactly 7 consecutive cycles; run_cycles=0 → never high, proceeds to dump.
- dump_words=3 after preloading dmem {0xA,0xB,0xC}, out_ready low 5 cycles on word 1 → out_data 0xA,0xB,0xC in order, word 1 held stable, done pulses once.
- All counts 0 → LD_I, LD_D and RUN each take 1 cycle, then DUMP_RD pulses done; no memory strobes; start while busy has no effect.
